// File: rtl/design_1_mul_pkg.sv
// Shared types and constants for the multiplier arbiter.
package design_1_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MUL_LAT_MIN = 2;
  localparam int STAT_W      = 32;

endpackage

// File: rtl/design_1_mul_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module design_1_mul_rr_pick
  import design_1_mul_pkg::*;
#(
  parameter int NumReq  = 4,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdWidth-1:0] idx_o,
  output logic               any_o
);

  int                 pos;
  logic [IdWidth-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest hit to ptr_i wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NumReq) begin
        pos = pos - NumReq;
      end
      pos_idx = IdWidth'(pos);
      if (req_i[pos_idx]) begin
        gnt_o          = '0;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/design_1_mul_arbiter.sv
// Round-robin shared unsigned multiplier, one op in flight, fixed latency, valid/ready result.
// Optional MUL_ARB_STATS_EN adds saturating op_count_o / stall_count_o outputs.
module design_1_mul_arbiter
  import design_1_mul_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int NumReq     = 4,
  parameter int MulLatency = 3,
  parameter int IdWidth    = $clog2(NumReq)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_a_i,
  input  logic [NumReq*DataWidth-1:0] req_b_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [2*DataWidth-1:0]      rsp_product_o,
  output logic [IdWidth-1:0]          rsp_id_o,
  output logic                        busy_o
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]           op_count_o,
  output logic [STAT_W-1:0]           stall_count_o
`endif
);

  localparam int CntW = (MulLatency > MUL_LAT_MIN) ? $clog2(MulLatency - 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MulLatency - MUL_LAT_MIN);

  state_e                 state_q, state_d;
  logic [IdWidth-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DataWidth-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DataWidth-1:0] product_q, product_d;
  logic [IdWidth-1:0]     id_q, id_d;

  logic [NumReq-1:0]      gnt;
  logic [IdWidth-1:0]     gnt_idx;
  logic                   any_valid;
  logic                   accept;
  logic [DataWidth-1:0]   ops_a [NumReq];
  logic [DataWidth-1:0]   ops_b [NumReq];
  logic [2*DataWidth-1:0] mul_res;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign ops_a[gi] = req_a_i[gi*DataWidth +: DataWidth];
      assign ops_b[gi] = req_b_i[gi*DataWidth +: DataWidth];
    end
  endgenerate

  design_1_mul_rr_pick #(
    .NumReq (NumReq),
    .IdWidth(IdWidth)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_valid)
  );

  assign mul_res = (2*DataWidth)'(a_q) * (2*DataWidth)'(b_q);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    id_d      = id_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          accept   = 1'b1;
          a_d      = ops_a[gnt_idx];
          b_d      = ops_b[gnt_idx];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IdWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d    = CntInit;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          product_d = mul_res;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      id_q      <= id_d;
    end
  end

  // Grant is combinational, so it must be masked while reset is held.
  assign req_ready_o   = (accept && rst_n) ? gnt : '0;
  assign rsp_valid_o   = (state_q == RESP);
  assign busy_o        = (state_q != IDLE);
  assign rsp_product_o = product_q;
  assign rsp_id_o      = id_q;

`ifdef MUL_ARB_STATS_EN
  logic [STAT_W-1:0] op_count_q, stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (rsp_valid_o && rsp_ready_i && (op_count_q != '1)) begin
        op_count_q <= op_count_q + 1'b1;
      end
      if (rsp_valid_o && !rsp_ready_i && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  assign op_count_o    = op_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_design_1_mul_arbiter.sv
// Randomized self-checking bench for design_1_mul_arbiter against a behavioural model.
module tb_design_1_mul_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int ML = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   vld = '0;
  logic [DW-1:0]   opa [NR];
  logic [DW-1:0]   opb [NR];
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [2*DW-1:0] rsp_product;
  logic [IW-1:0]   rsp_id;
  logic            busy;
`ifdef MUL_ARB_STATS_EN
  logic [31:0]     op_count, stall_count;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_ptr = 0;
  int last_acc = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_pack
      assign req_a[gi*DW +: DW] = opa[gi];
      assign req_b[gi*DW +: DW] = opb[gi];
    end
  endgenerate

  design_1_mul_arbiter #(
    .DataWidth (DW),
    .NumReq    (NR),
    .MulLatency(ML),
    .IdWidth   (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (vld),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_product_o(rsp_product),
    .rsp_id_o     (rsp_id),
    .busy_o       (busy)
`ifdef MUL_ARB_STATS_EN
    ,
    .op_count_o   (op_count),
    .stall_count_o(stall_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Round-robin rule: first valid requester at or after ptr, wrapping.
  function automatic int pick(input int ptr, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      int idx = (ptr + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      opa[i] = DW'($urandom);
      opb[i] = DW'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    model_ptr = 0;
  endtask

  // One full operation: grant, latency, response (with optional stalls), return to idle.
  task automatic run_op(input string tag, input int stall, input bit keep, input bit chk_gap,
                        output int g);
    int acc;
    int lat;
    logic [2*DW-1:0] ep;
    logic [NR-1:0] exp_rdy;
    rsp_ready = (stall == 0);
    #1;
    g = pick(model_ptr, vld);
    total++;
    if (g < 0) begin
      bad++;
      $display("FAIL %s stim: req_valid=%b has no requester", tag, vld);
      return;
    end
    exp_rdy = NR'(1) << g;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, exp_rdy);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_busy: busy=%b expected 0", tag, busy);
    end
    if (chk_gap) begin
      total++;
      if (cyc - last_acc != ML + 1) begin
        bad++;
        $display("FAIL %s gap: accept spacing=%0d expected %0d", tag, cyc - last_acc, ML + 1);
      end
    end
    acc = cyc;
    last_acc = cyc;
    ep = (2*DW)'(int'(opa[g]) * int'(opb[g]));
    model_ptr = (g + 1) % NR;
    @(posedge clk);
    #1;
    if (keep) begin
      opa[g] = DW'($urandom);
      opb[g] = DW'($urandom);
    end else begin
      vld[g] = 1'b0;
    end
    for (int w = 0; w < 20 && rsp_valid !== 1'b1; w++) begin
      total++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy_phase: req_ready=%b busy=%b expected 0000/1", tag, req_ready, busy);
      end
      @(negedge clk);
      #1;
    end
    lat = cyc - acc;
    total++;
    if (rsp_valid !== 1'b1 || lat != ML) begin
      bad++;
      $display("FAIL %s latency: rsp_valid=%b after %0d cycles expected 1 after %0d", tag, rsp_valid, lat, ML);
    end
    total++;
    if (rsp_product !== ep || rsp_id !== IW'(g)) begin
      bad++;
      $display("FAIL %s result: product=%h id=%0d expected %h id=%0d", tag, rsp_product, rsp_id, ep, g);
    end
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_product !== ep || rsp_id !== IW'(g) || req_ready !== '0) begin
        bad++;
        $display("FAIL %s hold: valid=%b product=%h id=%0d req_ready=%b expected 1/%h/%0d/0000",
                 tag, rsp_valid, rsp_product, rsp_id, req_ready, ep, g);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release: rsp_valid=%b busy=%b expected 0/0", tag, rsp_valid, busy);
    end
    $display("op %s: id=%0d a*b=%h stall=%0d", tag, g, ep, stall);
  endtask

  task automatic test_reset();
    vld = '1;
    randomize_ops();
    #2;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
          rsp_product !== '0 || rsp_id !== '0) begin
        bad++;
        $display("FAIL reset: req_ready=%b valid=%b busy=%b product=%h id=%0d expected all 0",
                 req_ready, rsp_valid, busy, rsp_product, rsp_id);
      end
      @(negedge clk);
      #1;
    end
    vld = '0;
    rst_n = 1'b1;
    model_ptr = 0;
    $display("reset checked");
  endtask

  task automatic test_single();
    int g;
    vld = 4'b0001;
    opa[0] = 8'hFF;
    opb[0] = 8'hFF;
    run_op("single", 0, 1'b0, 1'b0, g);
    total++;
    if (g != 0 || rsp_product !== 16'hFE01) begin
      bad++;
      $display("FAIL single: id=%0d product=%h expected 0 FE01", g, rsp_product);
    end
  endtask

  task automatic test_all_continuous();
    int g;
    apply_reset();
    vld = '1;
    randomize_ops();
    for (int i = 0; i < 5; i++) begin
      run_op("all4", 0, 1'b1, i > 0, g);
      total++;
      if (g != i % NR) begin
        bad++;
        $display("FAIL all4 order: grant %0d was %0d expected %0d", i, g, i % NR);
      end
    end
    vld = '0;
  endtask

  task automatic test_backpressure();
    int g;
    vld = 4'b0100;
    opa[2] = 8'h37;
    opb[2] = 8'h3D;
    run_op("backpressure", 5, 1'b0, 1'b0, g);
    total++;
    if (g != 2 || rsp_product !== 16'h0D1B) begin
      bad++;
      $display("FAIL backpressure: id=%0d product=%h expected 2 0D1B", g, rsp_product);
    end
  endtask

  task automatic test_ptr_wrap();
    int g;
    apply_reset();
    randomize_ops();
    vld = 4'b0100;
    run_op("wrap_a", 0, 1'b0, 1'b0, g);
    vld = 4'b0101;
    run_op("wrap_b", 0, 1'b0, 1'b0, g);
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL wrap: grant=%0d expected 0", g);
    end
    vld = 4'b0011;
    run_op("wrap_c", 0, 1'b0, 1'b0, g);
    total++;
    if (g != 1) begin
      bad++;
      $display("FAIL wrap_ptr: grant=%0d expected 1", g);
    end
    vld = '0;
  endtask

  task automatic test_idle();
    vld = '0;
    for (int i = 0; i < 4; i++) begin
      rsp_ready = i[0];
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle: req_ready=%b busy=%b valid=%b expected 0", req_ready, busy, rsp_valid);
      end
    end
    rsp_ready = 1'b1;
    $display("idle checked");
  endtask

  task automatic test_reset_mid_busy();
    int g;
    vld = 4'b0001;
    randomize_ops();
    #1;
    g = pick(model_ptr, vld);
    total++;
    if (req_ready !== (NR'(1) << g)) begin
      bad++;
      $display("FAIL rst_mid grant: req_ready=%b expected %b", req_ready, NR'(1) << g);
    end
    @(posedge clk);
    #1;
    vld = '1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || rsp_product !== '0) begin
      bad++;
      $display("FAIL rst_mid async: valid=%b busy=%b req_ready=%b product=%h expected 0",
               rsp_valid, busy, req_ready, rsp_product);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
        bad++;
        $display("FAIL rst_mid hold: valid=%b req_ready=%b expected 0", rsp_valid, req_ready);
      end
    end
    rst_n = 1'b1;
    model_ptr = 0;
    vld = 4'b1100;
    run_op("after_rst", 0, 1'b0, 1'b0, g);
    total++;
    if (g != 2) begin
      bad++;
      $display("FAIL rst_mid first: grant=%0d expected 2", g);
    end
    vld = '0;
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 40; n++) begin
      vld = NR'($urandom_range(1, (1 << NR) - 1));
      randomize_ops();
      run_op($sformatf("rnd%0d", n), int'($urandom_range(0, 3)), 1'($urandom), 1'b0, g);
      if ($urandom_range(0, 3) == 0) begin
        vld = '0;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== '0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL rnd idle: req_ready=%b busy=%b expected 0", req_ready, busy);
        end
      end
    end
    vld = '0;
  endtask

`ifdef MUL_ARB_STATS_EN
  task automatic test_stats();
    int g;
    apply_reset();
    total++;
    if (op_count !== 32'd0 || stall_count !== 32'd0) begin
      bad++;
      $display("FAIL stats reset: op=%0d stall=%0d expected 0 0", op_count, stall_count);
    end
    randomize_ops();
    vld = 4'b0001;
    run_op("stat0", 2, 1'b0, 1'b0, g);
    vld = 4'b0010;
    run_op("stat1", 0, 1'b0, 1'b0, g);
    vld = 4'b0100;
    run_op("stat2", 0, 1'b0, 1'b0, g);
    total++;
    if (op_count !== 32'd3 || stall_count !== 32'd2) begin
      bad++;
      $display("FAIL stats count: op=%0d stall=%0d expected 3 2", op_count, stall_count);
    end
    apply_reset();
    total++;
    if (op_count !== 32'd0 || stall_count !== 32'd0) begin
      bad++;
      $display("FAIL stats clear: op=%0d stall=%0d expected 0 0", op_count, stall_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    test_reset();
    test_single();
    test_all_continuous();
    test_backpressure();
    test_ptr_wrap();
    test_idle();
    test_reset_mid_busy();
    test_random();
`ifdef MUL_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
